// File: rtl/dcf77_pkg.sv
// dcf77_pkg: shared state encoding, error codes and frame bit positions
package dcf77_pkg;
  typedef enum logic [1:0] {HUNT, COLLECT, CHECK, LOAD} state_t;
  localparam logic [2:0] E_ACK = 3'd0;
  localparam logic [2:0] E_OVF = 3'd1;
  localparam logic [2:0] E_CNT = 3'd2;
  localparam logic [2:0] E_START = 3'd3;
  localparam logic [2:0] E_P1 = 3'd4;
  localparam logic [2:0] E_P2 = 3'd5;
  localparam logic [2:0] E_P3 = 3'd6;
  localparam logic [2:0] E_BCD = 3'd7;
  localparam int START = 20;
  localparam int MIN_LO = 21;
  localparam int P1 = 28;
  localparam int HOUR_LO = 29;
  localparam int P2 = 35;
  localparam int DATE_LO = 36;
  localparam int P3 = 58;
endpackage

// File: rtl/dcf77_frame_check.sv
// dcf77_frame_check: combinational validation of one collected DCF77 minute frame
// bits_i: frame bits (bit n = n-th second), count_i: bits collected
// pass_o: frame valid, code_o: first failing check, min_bcd_o/hour_bcd_o: decoded time
module dcf77_frame_check
  import dcf77_pkg::*;
#(
  parameter int FRAME_BITS = 59
) (
  input  logic [P3:0] bits_i,
  input  logic [5:0]  count_i,
  output logic        pass_o,
  output logic [2:0]  code_o,
  output logic [7:0]  min_bcd_o,
  output logic [7:0]  hour_bcd_o
);
  logic [3:0] mu, mt, hu, ht;
  logic bcd_bad;
  assign mu = bits_i[MIN_LO+:4];
  assign mt = {1'b0, bits_i[MIN_LO+4+:3]};
  assign hu = bits_i[HOUR_LO+:4];
  assign ht = {2'b0, bits_i[HOUR_LO+4+:2]};
  assign bcd_bad = (mu > 4'd9) | (mt > 4'd5) | (hu > 4'd9) | (ht > 4'd2) | (ht == 4'd2 && hu > 4'd3);
  // parity ranges include their parity bit, so even parity means XOR == 0
  assign code_o = count_i != 6'(FRAME_BITS) ? E_CNT :
                  !bits_i[START]            ? E_START :
                  ^bits_i[P1:MIN_LO]        ? E_P1 :
                  ^bits_i[P2:HOUR_LO]       ? E_P2 :
                  ^bits_i[P3:DATE_LO]       ? E_P3 :
                  bcd_bad                   ? E_BCD : E_ACK;
  // code 0 is never produced by a check, so it doubles as "all checks passed"
  assign pass_o = code_o == E_ACK;
  assign min_bcd_o = {mt, mu};
  assign hour_bcd_o = {ht, hu};
endmodule

// File: rtl/dcf77_frame_sync_ctrl.sv
// dcf77_frame_sync_ctrl: collects DCF77 bits, validates each minute frame and loads the time counters
// in: qzt_clk, reset, bit_strobe/bit_value (bit detector), minute_strobe (minute mark), load_ack
// out: load_req/load_min/load_hour (counter load), frame_ok/frame_err/err_code, bit_index, synced
module dcf77_frame_sync_ctrl
  import dcf77_pkg::*;
#(
  parameter int FRAME_BITS = 59,
  parameter int MAX_ERRS = 2
) (
  input  logic       qzt_clk,
  input  logic       reset,
  input  logic       bit_strobe,
  input  logic       bit_value,
  input  logic       minute_strobe,
  input  logic       load_ack,
  output logic       load_req,
  output logic [7:0] load_min,
  output logic [7:0] load_hour,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic [5:0] bit_index,
  output logic       synced
);
  state_t state_q, state_d;
  logic [P3:0] sr_q, sr_d;
  logic [5:0] idx_q, idx_d;
  logic [2:0] code_q, code_d;
  logic [7:0] min_q, min_d, hour_q, hour_d;
  logic [3:0] cnt_q, cnt_d, cnt_inc;
  logic ok_q, ok_d, err_q, err_d, req_q, req_d, sync_q, sync_d;
  logic bs_q, bs_prev_q, ms_q, ms_prev_q, bv_q;
  logic b_edge, m_edge, chk_pass;
  logic [2:0] chk_code;
  logic [7:0] chk_min, chk_hour;
  dcf77_frame_check #(.FRAME_BITS(FRAME_BITS)) u_check (
    .bits_i    (sr_q),
    .count_i   (idx_q),
    .pass_o    (chk_pass),
    .code_o    (chk_code),
    .min_bcd_o (chk_min),
    .hour_bcd_o(chk_hour)
  );
  assign b_edge = bs_q & ~bs_prev_q;
  assign m_edge = ms_q & ~ms_prev_q;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 4'd1;
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    idx_d = idx_q;
    code_d = code_q;
    min_d = min_q;
    hour_d = hour_q;
    cnt_d = cnt_q;
    ok_d = 1'b0;
    err_d = 1'b0;
    req_d = req_q;
    sync_d = sync_q;
    case (state_q)
      HUNT: begin
        if (m_edge) begin
          idx_d = '0;
          state_d = COLLECT;
        end
      end
      COLLECT, LOAD: begin
        if (state_q == LOAD && load_ack) begin
          req_d = 1'b0;
          sync_d = 1'b1;
          cnt_d = '0;
          state_d = COLLECT;
        end
        // a minute edge wins over a simultaneous bit edge; that bit is dropped
        if (m_edge) begin
          if (state_q == LOAD && !load_ack) begin
            req_d = 1'b0;
            code_d = E_ACK;
            err_d = 1'b1;
            cnt_d = cnt_inc;
            if (cnt_inc >= 4'(MAX_ERRS)) sync_d = 1'b0;
          end
          state_d = CHECK;
        end else if (b_edge) begin
          if (idx_q < 6'(FRAME_BITS)) begin
            sr_d[idx_q] = bv_q;
            idx_d = idx_q + 6'd1;
          end else begin
            code_d = E_OVF;
            err_d = 1'b1;
            cnt_d = cnt_inc;
            req_d = 1'b0;
            sync_d = 1'b0;
            state_d = HUNT;
          end
        end
      end
      CHECK: begin
        idx_d = '0;
        if (chk_pass) begin
          min_d = chk_min;
          hour_d = chk_hour;
          ok_d = 1'b1;
          req_d = 1'b1;
          state_d = LOAD;
        end else begin
          code_d = chk_code;
          err_d = 1'b1;
          cnt_d = cnt_inc;
          if (cnt_inc >= 4'(MAX_ERRS)) sync_d = 1'b0;
          state_d = COLLECT;
        end
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge qzt_clk) begin
    if (reset) begin
      state_q <= HUNT;
      sr_q <= '0;
      idx_q <= '0;
      code_q <= '0;
      min_q <= '0;
      hour_q <= '0;
      cnt_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      req_q <= 1'b0;
      sync_q <= 1'b0;
      bs_q <= 1'b0;
      bs_prev_q <= 1'b0;
      ms_q <= 1'b0;
      ms_prev_q <= 1'b0;
      bv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      idx_q <= idx_d;
      code_q <= code_d;
      min_q <= min_d;
      hour_q <= hour_d;
      cnt_q <= cnt_d;
      ok_q <= ok_d;
      err_q <= err_d;
      req_q <= req_d;
      sync_q <= sync_d;
      bs_q <= bit_strobe;
      bs_prev_q <= bs_q;
      ms_q <= minute_strobe;
      ms_prev_q <= ms_q;
      bv_q <= bit_value;
    end
  end
  assign load_req = req_q;
  assign load_min = min_q;
  assign load_hour = hour_q;
  assign frame_ok = ok_q;
  assign frame_err = err_q;
  assign err_code = code_q;
  assign bit_index = idx_q;
  assign synced = sync_q;
endmodule

// File: tb/tb_dcf77_frame_sync_ctrl.sv
// tb_dcf77_frame_sync_ctrl: scoreboard bench for the DCF77 frame sync controller
module tb_dcf77_frame_sync_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bit_strobe = 1'b0;
  logic bit_value = 1'b0;
  logic minute_strobe = 1'b0;
  logic load_ack = 1'b0;
  logic load_req, frame_ok, frame_err, synced;
  logic [7:0] load_min, load_hour;
  logic [2:0] err_code;
  logic [5:0] bit_index;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic ok;
    logic [2:0] code;
    logic [7:0] mn;
    logic [7:0] hr;
  } exp_t;
  exp_t exp_q[$];
  logic [58:0] f1, f2, fa, fb, fc;
  dcf77_frame_sync_ctrl dut (
    .qzt_clk      (clk),
    .reset        (reset),
    .bit_strobe   (bit_strobe),
    .bit_value    (bit_value),
    .minute_strobe(minute_strobe),
    .load_ack     (load_ack),
    .load_req     (load_req),
    .load_min     (load_min),
    .load_hour    (load_hour),
    .frame_ok     (frame_ok),
    .frame_err    (frame_err),
    .err_code     (err_code),
    .bit_index    (bit_index),
    .synced       (synced)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [58:0] mk(input logic [3:0] mu, input logic [2:0] mt, input logic [3:0] hu, input logic [1:0] ht);
    logic [58:0] f;
    f = '0;
    f[19:0] = 20'hA5C3;
    f[20] = 1'b1;
    f[24:21] = mu;
    f[27:25] = mt;
    f[28] = ^f[27:21];
    f[32:29] = hu;
    f[34:33] = ht;
    f[35] = ^f[34:29];
    f[57:36] = 22'h2A5F3;
    f[58] = ^f[57:36];
    return f;
  endfunction
  task automatic push_ok(input logic [7:0] mn, input logic [7:0] hr);
    exp_t e;
    e.ok = 1'b1;
    e.code = 3'd0;
    e.mn = mn;
    e.hr = hr;
    exp_q.push_back(e);
  endtask
  task automatic push_err(input logic [2:0] code);
    exp_t e;
    e.ok = 1'b0;
    e.code = code;
    e.mn = 8'h00;
    e.hr = 8'h00;
    exp_q.push_back(e);
  endtask
  task automatic send_bit(input logic v);
    @(negedge clk);
    bit_value = v;
    bit_strobe = 1'b1;
    repeat (2) @(negedge clk);
    bit_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_min();
    @(negedge clk);
    minute_strobe = 1'b1;
    repeat (2) @(negedge clk);
    minute_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_both();
    @(negedge clk);
    bit_value = 1'b1;
    bit_strobe = 1'b1;
    minute_strobe = 1'b1;
    repeat (2) @(negedge clk);
    bit_strobe = 1'b0;
    minute_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_bits(input logic [58:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[i]);
  endtask
  task automatic ack_once();
    @(negedge clk);
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_req"}, load_req, 0);
    check({tag, "_ok"}, frame_ok, 0);
    check({tag, "_err"}, frame_err, 0);
    check({tag, "_code"}, err_code, 0);
    check({tag, "_idx"}, bit_index, 0);
    check({tag, "_sync"}, synced, 0);
    check({tag, "_min"}, load_min, 0);
    check({tag, "_hour"}, load_hour, 0);
  endtask
  always @(negedge clk) begin
    if (!reset && (frame_ok || frame_err)) begin
      exp_t e;
      if (exp_q.size() == 0) check("unexpected_evt", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("evt_kind", frame_ok, e.ok);
        if (e.ok) begin
          check("evt_min", load_min, e.mn);
          check("evt_hour", load_hour, e.hr);
          check("evt_req_set", load_req, 1);
        end else begin
          check("evt_code", err_code, e.code);
          check("evt_req_clr", load_req, 0);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  initial begin
    f1 = mk(4'd4, 3'd3, 4'd2, 2'd1);
    f2 = f1;
    f2[28] = ~f2[28];
    fa = mk(4'd5, 3'd4, 4'd7, 2'd0);
    fb = mk(4'd6, 3'd4, 4'd8, 2'd0);
    fc = mk(4'd4, 3'd3, 4'd5, 2'd2);
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    send_bit(1'b1);
    check("hunt_ignore", bit_index, 0);
    send_min();
    check("collect_start", bit_index, 0);
    send_bits(f1, 59);
    check("idx_59", bit_index, 59);
    push_ok(8'h34, 8'h12);
    send_min();
    check("req_set", load_req, 1);
    check("sync_pre_ack", synced, 0);
    repeat (3) @(negedge clk);
    check("req_held", load_req, 1);
    ack_once();
    check("req_dropped", load_req, 0);
    check("sync_after_ack", synced, 1);
    send_bits(f2, 59);
    push_err(3'd4);
    send_min();
    check("p1_idx", bit_index, 0);
    check("p1_code", err_code, 4);
    check("p1_req", load_req, 0);
    check("p1_sync", synced, 1);
    send_bits(f1, 58);
    push_err(3'd2);
    send_min();
    check("short_code", err_code, 2);
    check("short_sync", synced, 0);
    send_bits(f1, 59);
    push_err(3'd1);
    send_bit(1'b0);
    check("ovf_code", err_code, 1);
    check("ovf_sync", synced, 0);
    send_bit(1'b1);
    send_min();
    check("rehunt_idx", bit_index, 0);
    send_bits(f1, 58);
    push_err(3'd2);
    send_both();
    check("both_idx", bit_index, 0);
    check("both_code", err_code, 2);
    send_bits(fa, 59);
    push_ok(8'h45, 8'h07);
    send_min();
    check("a_req", load_req, 1);
    send_bits(fb, 59);
    check("a_req_wait", load_req, 1);
    check("b_idx", bit_index, 59);
    push_err(3'd0);
    push_ok(8'h46, 8'h08);
    send_min();
    check("b_req", load_req, 1);
    check("b_min", load_min, 8'h46);
    check("b_code", err_code, 0);
    ack_once();
    check("b_sync", synced, 1);
    check("b_req_clr", load_req, 0);
    send_bits(fc, 59);
    push_err(3'd7);
    send_min();
    check("h25_sync1", synced, 1);
    send_bits(fc, 59);
    push_err(3'd7);
    send_min();
    check("h25_sync2", synced, 0);
    check("h25_code", err_code, 7);
    send_bits(f1, 30);
    check("idx_30", bit_index, 30);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    reset = 1'b0;
    send_bits(f1, 3);
    check("post_reset_ignore", bit_index, 0);
    send_min();
    send_bits(f1, 2);
    check("post_reset_collect", bit_index, 2);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
